// File: rtl/adc_sample_uart_tx.sv
// Buffers ADC sample bytes in a FIFO and serializes them as 8N1 UART frames.
// Optional build macro ADC_UART_ASCII_HEX_EN sends each sample as "HH\r\n" in ASCII hex.
module adc_sample_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          i_clk_100MHz,
    input  logic                          i_reset_n,
    input  logic [7:0]                    i_sample,
    input  logic                          i_sample_valid,
    output logic                          o_uart_tx,
    output logic                          o_busy,
    output logic                          o_fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_nxt;
    logic [BAUD_W-1:0]  baud;
    logic               baud_last;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push, pop, load;
    logic [7:0]         load_byte;

`ifdef ADC_UART_ASCII_HEX_EN
    logic [1:0]         char_idx;
    logic [7:0]         sample_reg;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] ascii_char(input logic [1:0] idx, input logic [7:0] s);
        case (idx)
            2'd0:    return hex_char(s[7:4]);
            2'd1:    return hex_char(s[3:0]);
            2'd2:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction
`endif

    assign o_fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign o_fifo_count = count;
    assign o_busy       = (state != IDLE) || (count != '0);
    assign push         = i_sample_valid && !o_fifo_full;
    assign baud_last    = (baud == BAUD_LAST);

    always_comb begin
        pop       = 1'b0;
        load      = 1'b0;
        load_byte = mem[rd_ptr];
`ifdef ADC_UART_ASCII_HEX_EN
        // Only the first character of a sample consumes a FIFO entry.
        pop  = (state == IDLE) && (char_idx == 2'd0) && (count != '0);
        load = (state == IDLE) && ((char_idx != 2'd0) || (count != '0));
        if (char_idx != 2'd0)
            load_byte = ascii_char(char_idx, sample_reg);
        else
            load_byte = hex_char(mem[rd_ptr][7:4]);
`else
        pop  = (state == IDLE) && (count != '0);
        load = pop;
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (load) state_nxt = START;
            START: if (baud_last) state_nxt = DATA;
            DATA:  if (baud_last && bit_idx == 3'd7) state_nxt = STOP;
            STOP:  if (baud_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_100MHz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            baud       <= '0;
            bit_idx    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
            o_uart_tx  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == IDLE || state_nxt != state || baud_last)
                baud <= '0;
            else
                baud <= baud + 1'b1;
            if (state != DATA)
                bit_idx <= '0;
            else if (baud_last)
                bit_idx <= bit_idx + 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Fullness is judged on the registered count, before any same-cycle pop.
            if (i_sample_valid && o_fifo_full)
                o_overflow <= 1'b1;
            case (state)
                START:   o_uart_tx <= 1'b0;
                DATA:    o_uart_tx <= shreg[0];
                default: o_uart_tx <= 1'b1;
            endcase
        end
    end

`ifdef ADC_UART_ASCII_HEX_EN
    always_ff @(posedge i_clk_100MHz or negedge i_reset_n) begin
        if (!i_reset_n)
            char_idx <= '0;
        else if (load)
            char_idx <= char_idx + 1'b1;
    end

    always_ff @(posedge i_clk_100MHz) begin
        if (pop)
            sample_reg <= mem[rd_ptr];
    end
`endif

    always_ff @(posedge i_clk_100MHz) begin
        if (push)
            mem[wr_ptr] <= i_sample;
        if (load)
            shreg <= load_byte;
        else if (state == DATA && baud_last)
            shreg <= {1'b0, shreg[7:1]};
    end

endmodule

// File: tb/tb_adc_sample_uart_tx.sv
// Scoreboard bench for adc_sample_uart_tx: a serial-line monitor decodes frames and
// compares them against bytes queued by the directed stimulus.
module tb_adc_sample_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef ADC_UART_ASCII_HEX_EN
    localparam int FRAMES = 4;
`else
    localparam int FRAMES = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sample = 8'h00;
    logic       valid = 1'b0;
    logic       tx, busy, full, overflow;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int reset_gen = 0;
    logic [7:0] exp_q[$];
    int starts[$];

    adc_sample_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk_100MHz   (clk),
        .i_reset_n      (rst_n),
        .i_sample       (sample),
        .i_sample_valid (valid),
        .o_uart_tx      (tx),
        .o_busy         (busy),
        .o_fifo_full    (full),
        .o_fifo_count   (count),
        .o_overflow     (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] hex_ch(input logic [3:0] n);
        logic [7:0] c;
        c = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
        return c;
    endfunction

    task automatic expect_sample(input logic [7:0] b);
`ifdef ADC_UART_ASCII_HEX_EN
        exp_q.push_back(hex_ch(b[7:4]));
        exp_q.push_back(hex_ch(b[3:0]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`else
        exp_q.push_back(b);
`endif
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 5000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Line monitor: samples the middle of every bit of each frame
    initial begin : monitor
        logic [7:0] b;
        logic       st, sp;
        int         gen;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                gen = reset_gen;
                starts.push_back(cyc);
                repeat (2) @(negedge clk);
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                sp = tx;
                if (gen == reset_gen) begin
                    check("start_bit", 32'(st), 32'd0);
                    check("stop_bit", 32'(sp), 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame actual=%0h required=none", b);
                    end else begin
                        check("frame_byte", 32'(b), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte and latency
        sample = 8'hA5; valid = 1'b1; expect_sample(8'hA5);
        @(negedge clk); valid = 1'b0;
        check("lat_count_n", 32'(count), 32'd1);
        check("lat_tx_n", 32'(tx), 32'd1);
        @(negedge clk);
        check("lat_tx_n1", 32'(tx), 32'd1);
        @(negedge clk);
        check("lat_tx_n2", 32'(tx), 32'd0);
        repeat (38) @(negedge clk);
`ifndef ADC_UART_ASCII_HEX_EN
        check("busy_in_stop", 32'(busy), 32'd1);
`endif
        @(negedge clk);
`ifndef ADC_UART_ASCII_HEX_EN
        check("busy_after_stop", 32'(busy), 32'd0);
`endif
        wait_drain();

        // Back-to-back strobes
        n0 = starts.size();
        sample = 8'h00; valid = 1'b1; expect_sample(8'h00);
        @(negedge clk);
        check("b2b_count0", 32'(count), 32'd1);
        sample = 8'hFF; expect_sample(8'hFF);
        @(negedge clk);
        check("b2b_count1", 32'(count), 32'd1);
        sample = 8'h3C; expect_sample(8'h3C);
        @(negedge clk); valid = 1'b0;
        check("b2b_count2", 32'(count), 32'd2);
        repeat (39) @(negedge clk);
`ifndef ADC_UART_ASCII_HEX_EN
        check("b2b_count_before_pop", 32'(count), 32'd2);
`endif
        @(negedge clk);
`ifndef ADC_UART_ASCII_HEX_EN
        check("b2b_count_after_pop", 32'(count), 32'd1);
`endif
        wait_drain();
        check("b2b_frames", 32'(starts.size() - n0), 32'(3 * FRAMES));
        check("b2b_period1", 32'(starts[n0+1] - starts[n0]), 32'd41);
        check("b2b_period2", 32'(starts[n0+2] - starts[n0+1]), 32'd41);

        // Overflow: six strobes into a four-entry FIFO
        for (int i = 1; i <= 6; i++) begin
            sample = 8'(i); valid = 1'b1;
            if (i <= 5) expect_sample(8'(i));
            @(negedge clk);
        end
        valid = 1'b0;
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        wait_drain();
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_full_clear", 32'(full), 32'd0);

        // Reset during data bit 3 of 0x0F
        sample = 8'h0F; valid = 1'b1; expect_sample(8'h0F);
        @(negedge clk); valid = 1'b0;
        repeat (18) @(negedge clk);
        #2 rst_n = 1'b0; reset_gen++; exp_q.delete();
        #1;
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_count", 32'(count), 32'd0);
        check("rst_mid_overflow", 32'(overflow), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);

        // Reset while the start bit is driving the line low
        sample = 8'h55; valid = 1'b1; expect_sample(8'h55);
        @(negedge clk); valid = 1'b0;
        repeat (2) @(negedge clk);
        check("start_low", 32'(tx), 32'd0);
        #2 rst_n = 1'b0; reset_gen++; exp_q.delete();
        #1;
        check("rst_async_tx", 32'(tx), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);

        sample = 8'h81; valid = 1'b1; expect_sample(8'h81);
        @(negedge clk); valid = 1'b0;
        wait_drain();

        // Full FIFO with a strobe on the IDLE pop cycle
        check("fp_overflow_pre", 32'(overflow), 32'd0);
        sample = 8'h11; valid = 1'b1; expect_sample(8'h11);
        @(negedge clk);
        for (int i = 2; i <= 5; i++) begin
            sample = 8'(i * 8'h11); expect_sample(8'(i * 8'h11));
            @(negedge clk);
        end
        valid = 1'b0;
        check("fp_full", 32'(full), 32'd1);
        repeat (37) @(negedge clk);
        sample = 8'hEE; valid = 1'b1;
        @(negedge clk); valid = 1'b0;
`ifdef ADC_UART_ASCII_HEX_EN
        check("fp_count", 32'(count), 32'd4);
`else
        check("fp_count", 32'(count), 32'd3);
`endif
        check("fp_overflow", 32'(overflow), 32'd1);
        wait_drain();

`ifdef ADC_UART_ASCII_HEX_EN
        sample = 8'h3A; valid = 1'b1; expect_sample(8'h3A);
        @(negedge clk); valid = 1'b0;
        wait_drain();
        sample = 8'hF0; valid = 1'b1; expect_sample(8'hF0);
        @(negedge clk); valid = 1'b0;
        wait_drain();
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
